// File: rtl/irq_ack_responder.sv
// Core-side interrupt responder: captures requests, picks the lowest enabled line,
// runs the request/take/ack handshake and holds off new requests until mret.
module irq_ack_responder #(
    parameter int N_IRQ = 32,
    parameter int ID_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             irq_i,
    input  logic [ID_W-1:0]  irq_id_i,
    output logic             irq_ack_o,
    output logic [ID_W-1:0]  irq_ack_id_o,
    input  logic             irq_enable_i,
    input  logic [N_IRQ-1:0] irq_mask_i,
    output logic             core_irq_req_o,
    output logic [ID_W-1:0]  core_irq_id_o,
    input  logic             core_irq_take_i,
    input  logic             core_mret_i,
    output logic [N_IRQ-1:0] irq_pending_o,
    output logic [CNT_W-1:0] irq_count_o,
    output logic [CNT_W-1:0] irq_latency_o
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_ACK     = 2'd2;
    localparam logic [1:0] S_SERVICE = 2'd3;

    logic [1:0]       r_state;
    logic [N_IRQ-1:0] r_pending;
    logic [ID_W-1:0]  r_sel_id;
    logic [CNT_W-1:0] r_lat;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_latency;
    logic             r_req;
    logic [ID_W-1:0]  r_req_id;
    logic             r_ack;
    logic [ID_W-1:0]  r_ack_id;

    logic [N_IRQ-1:0] w_set;
    logic [N_IRQ-1:0] w_sel_oh;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_cand;
    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic             w_sel_en;

    // Out-of-range IDs match no line and are dropped here.
    always_comb begin
        w_set    = '0;
        w_sel_oh = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            w_set[i]    = irq_i && (irq_id_i == ID_W'(i));
            w_sel_oh[i] = (r_sel_id == ID_W'(i));
        end
    end

    assign w_clr    = (r_state == S_ACK) ? w_sel_oh : '0;
    assign w_cand   = irq_enable_i ? (r_pending & irq_mask_i) : '0;
    assign w_sel_en = irq_enable_i && |(irq_mask_i & w_sel_oh);

    // Scan downward so the lowest set index is written last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_any = 1'b1;
                w_win = ID_W'(i);
            end
        end
    end

    // Clear beats a same-cycle set: the source still drives its level during ACK.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending | w_set) & ~w_clr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_sel_id  <= '0;
            r_lat     <= '0;
            r_count   <= '0;
            r_latency <= '0;
            r_req     <= 1'b0;
            r_req_id  <= '0;
            r_ack     <= 1'b0;
            r_ack_id  <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state  <= S_REQ;
                        r_sel_id <= w_win;
                        r_lat    <= '0;
                        r_req    <= 1'b1;
                        r_req_id <= w_win;
                    end
                end
                S_REQ: begin
                    if (r_lat != {CNT_W{1'b1}}) begin
                        r_lat <= r_lat + 1'b1;
                    end
                    if (core_irq_take_i) begin
                        r_state  <= S_ACK;
                        r_req    <= 1'b0;
                        r_req_id <= '0;
                        r_ack    <= 1'b1;
                        r_ack_id <= r_sel_id;
                    end else if (!w_sel_en) begin
                        r_state  <= S_IDLE;
                        r_req    <= 1'b0;
                        r_req_id <= '0;
                    end
                end
                S_ACK: begin
                    r_state   <= S_SERVICE;
                    r_ack     <= 1'b0;
                    r_ack_id  <= '0;
                    r_count   <= r_count + 1'b1;
                    r_latency <= r_lat;
                end
                S_SERVICE: begin
                    if (core_mret_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign irq_ack_o      = r_ack;
    assign irq_ack_id_o   = r_ack_id;
    assign core_irq_req_o = r_req;
    assign core_irq_id_o  = r_req_id;
    assign irq_pending_o  = r_pending;
    assign irq_count_o    = r_count;
    assign irq_latency_o  = r_latency;

endmodule

// File: doc/irq_ack_responder.md
Name: irq_ack_responder

Overview:
Core-side responder for the external interrupt request/acknowledge handshake. It captures `irq_i`/`irq_id_i` requests into a pending register and selects one under a global enable and a per-line mask. It presents the selected request to the core, returns a one-cycle `irq_ack_o` with the serviced ID to the requesting source, and holds off further requests until the core executes mret. It also exports pending state, a service count and the last request-to-take latency for the testbench.

Parameters:
- N_IRQ, 32: number of interrupt lines; legal range 1..32.
- ID_W, 5: interrupt ID width; must satisfy 2^ID_W >= N_IRQ.
- CNT_W, 32: width of the service counter and the latency counter.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- irq_i  in  1  request level from the source; held until acknowledged.
- irq_id_i  in  ID_W  ID of the request.
- irq_ack_o  out  1  one-cycle acknowledge pulse to the source.
- irq_ack_id_o  out  ID_W  ID being acknowledged; valid while irq_ack_o=1, else 0.
- irq_enable_i  in  1  global interrupt enable (MIE).
- irq_mask_i  in  N_IRQ  per-line enable.
- core_irq_req_o  out  1  request to the core.
- core_irq_id_o  out  ID_W  ID presented to the core; 0 when not requesting.
- core_irq_take_i  in  1  core enters the handler this cycle.
- core_mret_i  in  1  core returns from the handler.
- irq_pending_o  out  N_IRQ  pending register.
- irq_count_o  out  CNT_W  number of acknowledged interrupts.
- irq_latency_o  out  CNT_W  REQ cycles of the last serviced interrupt.

Behaviour:
- Reset (async, any state, mid-handshake included):
  - state=IDLE; pending, sel_id, counters and every output = 0.
  - No ack pulse is emitted for an interrupted handshake.
- Capture:
  - Each cycle irq_i=1 with irq_id_i<N_IRQ sets pending[irq_id_i].
  - irq_id_i>=N_IRQ is ignored.
  - Re-setting an already-set bit has no effect.
- Arbitration: candidates = pending & irq_mask_i, considered only when irq_enable_i=1. The lowest index wins.
- FSM:
  - IDLE: if any candidate exists, latch sel_id and go to REQ; latency counter <= 0.
  - REQ:
    - core_irq_req_o=1 and core_irq_id_o=sel_id, registered so they appear the cycle after the IDLE decision.
    - The latency counter increments every REQ cycle, saturating at all-ones.
    - If core_irq_take_i=1, go to ACK. take has priority over withdrawal in the same cycle.
    - Else, if irq_enable_i=0 or irq_mask_i[sel_id]=0, withdraw: go to IDLE, with core_irq_req_o low from the next cycle. pending is unchanged.
  - ACK (one cycle):
    - irq_ack_o=1 and irq_ack_id_o=sel_id.
    - pending[sel_id] is cleared at the end of the cycle.
    - irq_count_o increments, wrapping modulo 2^CNT_W.
    - irq_latency_o <= latency counter, i.e. REQ cycles including the take cycle.
    - Go to SERVICE.
  - SERVICE: no new request is issued (no nesting). core_mret_i=1 returns to IDLE. Arbitration resumes in IDLE on the following cycle.
- Simultaneous set and clear of the same bit in the ACK cycle: clear wins, because the source's level is still high that cycle. Sets to other bits proceed normally.
- core_irq_take_i outside REQ is ignored. core_mret_i outside SERVICE is ignored.
- Mask or enable changes during SERVICE do not affect the in-flight interrupt.
- Minimum handshake: capture edge → REQ visible 2 cycles after irq_i first sampled → take → ACK pulse the cycle after take.

Test Plan:
- Basic handshake: irq_i=1, id=3, enable=1, mask=all-ones; take 2 cycles after core_irq_req_o rises.
  - Required: core_irq_id_o=3; single irq_ack_o pulse with irq_ack_id_o=3 the cycle after take.
  - Required: pending[3]=0 after the ack; irq_count_o=1; irq_latency_o=3.
- Priority: ids 7 and 2 pending together.
  - Required: 2 is serviced first; after mret, 7 is requested; irq_count_o=2.
- Withdrawal: REQ active for id 5, then irq_mask_i[5] cleared before take.
  - Required: core_irq_req_o drops the next cycle; pending[5] stays 1; no ack.
  - Required: re-enabling the mask bit re-requests id 5.
- Take and mask-drop in the same cycle: required ACK for that id (take wins).
- No nesting: new irq id 1 arrives during SERVICE.
  - Required: pending[1]=1, but core_irq_req_o stays 0 until core_mret_i, then id 1 is requested.
- Reset mid-REQ: assert rst_ni=0 asynchronously while in REQ.
  - Required: all outputs 0 immediately; no ack after release; pending=0.
